// File: rtl/cdc_arb_pkg.sv
// rtl/cdc_arb_pkg.sv - shared types and sizing helpers for the CDC transfer arbiter
// Purpose: FSM state type and counter-width helper used by cdc_xfer_arbiter.
// Ports: none (package).
package cdc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } cdc_arb_state_t;

  // Width of a down-counter that must hold max(hold, gap) - 1 and reach 0.
  function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
    int m;
    m = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cdc_rr_pick.sv
// rtl/cdc_rr_pick.sv - combinational round-robin picker
// Purpose: finds the first asserted request starting at ptr and wrapping around.
// Ports:
//   req      in   NUM_REQ  level requests
//   ptr      in   IDX_W    index searched first (highest priority)
//   win      out  NUM_REQ  one-hot winner, all zero when no request
//   win_idx  out  IDX_W    binary index of the winner, 0 when no request
module cdc_rr_pick #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx
);

  int   idx;
  logic found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found                = 1'b1;
        win[IDX_W'(idx)]     = 1'b1;
        win_idx              = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cdc_xfer_arbiter.sv
// rtl/cdc_xfer_arbiter.sv - source-domain scheduler for a bus-enable CDC synchronizer
// Purpose: round-robin arbitration of NUM_REQ requesters onto one synchronizer channel.
//   Each transfer latches the winner's word onto unsync_bus, raises bus_enable for
//   HOLD_CYCLES, then holds it low for GAP_CYCLES. The data stays put for the whole
//   HOLD+GAP window so the destination samples a stable word after its sync latency.
// Configuration: define CDC_ARB_TAG_EN to add the xfer_id output (winner index).
// Ports:
//   CLK         in   1                  source-domain clock
//   RST         in   1                  synchronous active-high reset
//   req         in   NUM_REQ            level request per requester
//   req_data    in   NUM_REQ*BUS_WIDTH  payload, slice i belongs to requester i
//   grant       out  NUM_REQ            one-hot single-cycle pulse on acceptance
//   unsync_bus  out  BUS_WIDTH          word presented to the synchronizer
//   bus_enable  out  1                  synchronizer enable pulse
//   busy        out  1                  high whenever the FSM is not idle
//   xfer_id     out  $clog2(NUM_REQ)    winner index (CDC_ARB_TAG_EN only)
module cdc_xfer_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int BUS_WIDTH   = 32,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [BUS_WIDTH-1:0]         unsync_bus,
  output logic                         bus_enable,
  output logic                         busy
`ifdef CDC_ARB_TAG_EN
  ,
  output logic [IDX_W-1:0]             xfer_id
`endif
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES, GAP_CYCLES);

  cdc_arb_state_t       state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     ptr;
  logic [NUM_REQ-1:0]   win;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     next_ptr;
  logic [BUS_WIDTH-1:0] win_data;
  logic                 any_req;
  logic                 start;

  cdc_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx)
  );

  assign any_req  = |req;
  assign next_ptr = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

  // A new transfer may start from IDLE, or directly at GAP expiry so that
  // back-to-back transfers run with period HOLD+GAP and no idle cycle.
  assign start = any_req && ((state == IDLE) || ((state == GAP) && (cnt == '0)));

  always_comb begin
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win[i]) win_data = req_data[i*BUS_WIDTH +: BUS_WIDTH];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      ptr        <= '0;
      grant      <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      busy       <= 1'b0;
`ifdef CDC_ARB_TAG_EN
      xfer_id    <= '0;
`endif
    end else begin
      grant <= '0;
      if (start) begin
        // Data is sampled only here; it is never re-read mid-transfer.
        state      <= HOLD;
        cnt        <= CNT_W'(HOLD_CYCLES - 1);
        ptr        <= next_ptr;
        grant      <= win;
        unsync_bus <= win_data;
        bus_enable <= 1'b1;
        busy       <= 1'b1;
`ifdef CDC_ARB_TAG_EN
        xfer_id    <= win_idx;
`endif
      end else begin
        case (state)
          HOLD: begin
            if (cnt == '0) begin
              state      <= GAP;
              cnt        <= CNT_W'(GAP_CYCLES - 1);
              bus_enable <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          GAP: begin
            if (cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end
          IDLE: begin
            busy       <= 1'b0;
            bus_enable <= 1'b0;
          end
          default: begin
            state      <= IDLE;
            busy       <= 1'b0;
            bus_enable <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cdc_xfer_arbiter.sv
// tb/tb_cdc_xfer_arbiter.sv - directed self-checking bench for cdc_xfer_arbiter
module tb_cdc_xfer_arbiter;

  logic         clk = 1'b0;
  logic         dclk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic [3:0]   grant;
  logic [31:0]  unsync_bus;
  logic         bus_enable;
  logic         busy;
`ifdef CDC_ARB_TAG_EN
  logic [1:0]   xfer_id;
`endif

  int total = 0;
  int bad   = 0;

  cdc_xfer_arbiter #(
    .NUM_REQ     (4),
    .BUS_WIDTH   (32),
    .HOLD_CYCLES (4),
    .GAP_CYCLES  (4)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .req        (req),
    .req_data   (req_data),
    .grant      (grant),
    .unsync_bus (unsync_bus),
    .bus_enable (bus_enable),
    .busy       (busy)
`ifdef CDC_ARB_TAG_EN
    ,
    .xfer_id    (xfer_id)
`endif
  );

  always #5 clk = ~clk;
  initial begin
    #3;
    forever #10 dclk = ~dclk;
  end

  // Destination side: 2-stage enable synchronizer, half-rate clock, captures on rising edge.
  logic        en_s1 = 1'b0;
  logic        en_s2 = 1'b0;
  logic        en_s3 = 1'b0;
  logic [31:0] sync_bus = '0;
  int          dst_cnt = 0;
  logic [31:0] dst_word [0:63];

  always @(posedge dclk) begin
    en_s1 <= bus_enable;
    en_s2 <= en_s1;
    en_s3 <= en_s2;
    if (en_s2 && !en_s3 && dst_cnt < 64) begin
      sync_bus          <= unsync_bus;
      dst_word[dst_cnt] <= unsync_bus;
      dst_cnt           <= dst_cnt + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int          base;
    logic [31:0] hold_word;
    logic [31:0] exp_grant;

    rst      = 1'b1;
    req      = '0;
    req_data = '0;
    step();
    step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_bus", unsync_bus, 32'h0);
    check("rst_en", 32'(bus_enable), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step();

    // Single request from idle.
    base = dst_cnt;
    req_data[2*32 +: 32] = 32'hA5A5_0002;
    req = 4'b0100;
    step();
    check("s1_grant", 32'(grant), 32'h4);
    check("s1_bus", unsync_bus, 32'hA5A5_0002);
    check("s1_en", 32'(bus_enable), 32'h1);
    check("s1_busy", 32'(busy), 32'h1);
    req = '0;
    for (int i = 1; i <= 8; i++) begin
      step();
      check("s1_en_seq", 32'(bus_enable), (i < 4) ? 32'h1 : 32'h0);
      check("s1_busy_seq", 32'(busy), (i < 8) ? 32'h1 : 32'h0);
    end
    check("s1_bus_kept", unsync_bus, 32'hA5A5_0002);
    repeat (4) step();
    check("s1_dst_pulses", 32'(dst_cnt - base), 32'h1);
    check("s1_dst_word", sync_bus, 32'hA5A5_0002);

    // All requesters held high: 0,1,2,3,0 every 8 cycles.
    do_reset();
    base = dst_cnt;
    for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = 32'h11 * i;
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      step();
      exp_grant = 32'h1 << (t % 4);
      check("s2_grant", 32'(grant), exp_grant);
      check("s2_bus", unsync_bus, 32'h11 * (t % 4));
`ifdef CDC_ARB_TAG_EN
      check("s2_xfer_id", 32'(xfer_id), 32'(t % 4));
`endif
      hold_word = 32'h11 * (t % 4);
      for (int s = 1; s <= 7; s++) begin
        step();
        check("s2_no_grant", 32'(grant), 32'h0);
        check("s2_bus_stable", unsync_bus, hold_word);
        check("s2_en", 32'(bus_enable), (s < 4) ? 32'h1 : 32'h0);
      end
    end
    req = '0;
    step();
    check("s2_idle", 32'(busy), 32'h0);
    repeat (6) step();
    check("s2_dst_pulses", 32'(dst_cnt - base), 32'h5);
    for (int k = 0; k < 5; k++) begin
      check("s2_dst_word", dst_word[base + k], 32'h11 * (k % 4));
    end

    // Late request: req[1] raised during HOLD of requester 0.
    do_reset();
    req_data[0*32 +: 32] = 32'hD000_0000;
    req = 4'b0001;
    step();
    check("s3_grant0", 32'(grant), 32'h1);
    req = '0;
    step();
    req_data[1*32 +: 32] = 32'hBBBB_0001;
    req = 4'b0010;
    for (int i = 3; i <= 8; i++) begin
      step();
      check("s3_wait", 32'(grant), 32'h0);
      check("s3_bus_hold", unsync_bus, 32'hD000_0000);
    end
    req_data[1*32 +: 32] = 32'hBBBB_0002;
    step();
    check("s3_grant1", 32'(grant), 32'h2);
    check("s3_bus", unsync_bus, 32'hBBBB_0002);
    req = '0;
    step();

    // Reset during HOLD cycle 2, then pointer must restart at 0.
    rst = 1'b1;
    step();
    check("s4_grant", 32'(grant), 32'h0);
    check("s4_en", 32'(bus_enable), 32'h0);
    check("s4_busy", 32'(busy), 32'h0);
    check("s4_bus", unsync_bus, 32'h0);
`ifdef CDC_ARB_TAG_EN
    check("s4_xfer_id", 32'(xfer_id), 32'h0);
`endif
    rst = 1'b0;
    req_data[0*32 +: 32] = 32'h0000_00A0;
    req_data[3*32 +: 32] = 32'h0000_00A3;
    req = 4'b1001;
    step();
    check("s4_first", 32'(grant), 32'h1);
    check("s4_first_bus", unsync_bus, 32'h0000_00A0);
    req = 4'b1000;
    repeat (8) step();
    check("s4_second", 32'(grant), 32'h8);
    check("s4_second_bus", unsync_bus, 32'h0000_00A3);
    req = '0;
    repeat (8) step();
    check("s4_idle", 32'(busy), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
